// File: rtl/axis_uart_rx.sv
// -----------------------------------------------------------------------------
// axis_uart_rx
//   UART 8N1 receiver producing single-byte AXI4-Stream beats. This is the
//   receive half of the AxisUart pair; axis_uart_tx is the transmit half.
//   The serial line passes through a 2-flop synchronizer. Each bit is sampled
//   at mid-bit, using a down-counting tic counter. The receiver validates the
//   start bit and checks the stop bit for framing errors.
//
// Parameters
//   ACLK_FREQUENCY  aclk frequency in Hz
//   BAUD_RATE       line baud rate used for synthesis builds
//   BAUD_RATE_SIM   baud rate used for simulation builds
//   TICS_PER_BEAT = ACLK_FREQUENCY / baud (integer division). It must be >= 4.
//
// Ports
//   aclk           clock
//   aresetn        asynchronous active-low reset
//   uart_rxd       serial input, idle high, asynchronous to aclk
//   rxbyte_tvalid  received byte valid
//   rxbyte_tready  downstream ready
//   rxbyte_tdata   received byte
//   rxbyte_tkeep   byte enable, tied to 1
//
// Optional feature: define AXIS_UART_RX_MAJORITY_EN to take each bit as the
//   2-of-3 majority of rxd_s at tic_cnt == 2, 1 and 0. Otherwise the receiver
//   takes a single sample at tic_cnt == 0. Frame timing is identical in both
//   builds.
//
// Handshake: a beat transfers on a cycle where tvalid && tready.
//   tvalid and tdata hold steady until that handshake happens.
//   A byte that completes while a beat is still waiting (tvalid && !tready)
//   is dropped, and the waiting beat is left untouched.
//   A byte that completes in the same cycle as a handshake replaces the
//   accepted beat, and tvalid stays high.
// -----------------------------------------------------------------------------
module axis_uart_rx #(
  parameter int ACLK_FREQUENCY = 200000000,
  parameter int BAUD_RATE      = 9600,
  parameter int BAUD_RATE_SIM  = 50000000
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       uart_rxd,
  output logic       rxbyte_tvalid,
  input  logic       rxbyte_tready,
  output logic [7:0] rxbyte_tdata,
  output logic       rxbyte_tkeep
);

`ifdef SYNTHESIS
  localparam bit SYNTH_BUILD = 1'b1;
`else
  localparam bit SYNTH_BUILD = 1'b0;
`endif
  localparam int USED_BAUD     = SYNTH_BUILD ? BAUD_RATE : BAUD_RATE_SIM;
  localparam int TICS_PER_BEAT = ACLK_FREQUENCY / USED_BAUD;
  localparam int TW            = $clog2(TICS_PER_BEAT);
  localparam logic [TW-1:0] TIC_FULL = TW'(TICS_PER_BEAT - 1);
  localparam logic [TW-1:0] TIC_HALF = TW'(TICS_PER_BEAT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic          rxd_meta, rxd_s;
  logic [TW-1:0] tic_cnt, tic_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          deliver;
  logic          bit_val;
  logic          tic_zero;

  // Reset to 1 (idle line) so that reset release never looks like a start edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_s    <= rxd_meta;
    end
  end

`ifdef AXIS_UART_RX_MAJORITY_EN
  // tic_cnt steps down by one every cycle inside a bit. A two-deep history
  // therefore holds the rxd_s values from tic_cnt == 2 and tic_cnt == 1.
  logic [1:0] hist;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) hist <= 2'b11;
    else          hist <= {hist[0], rxd_s};
  end
  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
`else
  assign bit_val = rxd_s;
`endif

  assign tic_zero = (tic_cnt == '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      tic_cnt <= '0;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
    end else begin
      state   <= state_nxt;
      tic_cnt <= tic_nxt;
      bit_cnt <= bit_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tic_nxt   = tic_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    deliver   = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          tic_nxt   = TIC_HALF;
          state_nxt = START;
        end
      end
      START: begin
        if (tic_zero) begin
          if (!bit_val) begin
            tic_nxt   = TIC_FULL;
            bit_nxt   = 3'd7;
            state_nxt = DATA;
          end else begin
            state_nxt = IDLE;   // too short to be a start bit
          end
        end else begin
          tic_nxt = tic_cnt - TW'(1);
        end
      end
      DATA: begin
        if (tic_zero) begin
          shift_nxt = {bit_val, shift[7:1]};
          tic_nxt   = TIC_FULL;
          if (bit_cnt == 3'd0) state_nxt = STOP;
          else                 bit_nxt   = bit_cnt - 3'd1;
        end else begin
          tic_nxt = tic_cnt - TW'(1);
        end
      end
      STOP: begin
        if (tic_zero) begin
          if (bit_val) begin
            deliver   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_HIGH;  // framing error: byte discarded
          end
        end else begin
          tic_nxt = tic_cnt - TW'(1);
        end
      end
      WAIT_HIGH: begin
        // A break holds the line low. Re-arm only after the line returns high.
        if (rxd_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rxbyte_tvalid <= 1'b0;
      rxbyte_tdata  <= 8'h00;
    end else if (deliver && (!rxbyte_tvalid || rxbyte_tready)) begin
      rxbyte_tvalid <= 1'b1;
      rxbyte_tdata  <= shift;
    end else if (rxbyte_tvalid && rxbyte_tready) begin
      rxbyte_tvalid <= 1'b0;
    end
  end

  assign rxbyte_tkeep = 1'b1;

endmodule

// File: tb/tb_axis_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_axis_uart_rx
//   Directed and randomized bench for axis_uart_rx.
//   Settings: 100 MHz aclk and 10 Mbaud, so TICS_PER_BEAT = 10.
//   Frames are built bit by bit from the 8N1 format.
//   The expected stream comes from a small sink model: a good frame is
//   delivered if nothing is waiting, it is held while the sink is stalled,
//   and it is dropped on overrun.
// -----------------------------------------------------------------------------
module tb_axis_uart_rx;

  localparam int TICS    = 10;
  localparam int LATENCY = 2 + TICS / 2 + 9 * TICS + 1;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       rxbyte_tready = 1'b1;
  logic       rxbyte_tvalid;
  logic [7:0] rxbyte_tdata;
  logic       rxbyte_tkeep;

  axis_uart_rx #(
    .ACLK_FREQUENCY(100000000),
    .BAUD_RATE     (10000000),
    .BAUD_RATE_SIM (10000000)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .uart_rxd      (uart_rxd),
    .rxbyte_tvalid (rxbyte_tvalid),
    .rxbyte_tready (rxbyte_tready),
    .rxbyte_tdata  (rxbyte_tdata),
    .rxbyte_tkeep  (rxbyte_tkeep)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  bit         model_held = 1'b0;
  logic [7:0] model_byte = 8'h00;
  int         rise_cyc = -1;
  logic       tvalid_d = 1'b0;

  // Beats are collected on the falling edge. Inputs only change 2 ns after
  // a rising edge, so the values seen here are the ones used at the next
  // rising edge.
  always @(negedge aclk) begin
    if (aresetn && rxbyte_tvalid && rxbyte_tready) got_q.push_back(rxbyte_tdata);
    if (rxbyte_tvalid && !tvalid_d && rise_cyc < 0) rise_cyc = cyc;
    tvalid_d = rxbyte_tvalid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok || model_held) return;
    if (rxbyte_tready) exp_q.push_back(b);
    else begin
      model_held = 1'b1;
      model_byte = b;
    end
  endfunction

  function automatic void model_release();
    if (model_held) exp_q.push_back(model_byte);
    model_held = 1'b0;
  endfunction

  task automatic check_stream(input string tag);
    int n;
    check({tag, " count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, " byte"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #2;
    end
  endtask

  // Drives one 8N1 frame, TICS cycles per bit. glitch >= 0 inverts the line
  // for that one cycle offset within the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10 * TICS; i++) begin
      uart_rxd = fr[i / TICS] ^ (i == glitch);
      tick(1);
    end
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1, -1);
    model_frame(b, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    logic [9:0] fr;
    int         start_cyc;
    int         gl;

    // reset state
    aresetn = 1'b0;
    tick(5);
    check("reset tvalid", rxbyte_tvalid, 1'b0);
    check("reset tdata", rxbyte_tdata, 8'h00);
    check("reset tkeep", rxbyte_tkeep, 1'b1);
    aresetn = 1'b1;
    tick(5);

    // 1: single frame, latency from the start edge to tvalid
    rise_cyc  = -1;
    start_cyc = cyc;
    send_good(8'hA5);
    tick(20);
    check("t1 latency", rise_cyc - start_cyc, LATENCY);
    check("t1 tkeep", rxbyte_tkeep, 1'b1);
    check_stream("t1");

    // 2: 3-cycle low glitch is not a start bit
    uart_rxd = 1'b0;
    tick(3);
    uart_rxd = 1'b1;
    tick(20);
    check_stream("t2 glitch");
    send_good(8'h3C);
    tick(20);
    check_stream("t2 after");

    // 3: framing error followed by a break, then a good frame
    send_frame(8'h3C, 1'b0, -1);
    model_frame(8'h3C, 1'b0);
    uart_rxd = 1'b0;
    tick(300);
    uart_rxd = 1'b1;
    tick(20);
    check_stream("t3 break");
    send_good(8'h81);
    tick(20);
    check_stream("t3 after");

    // 4: stalled sink, overrun drops the second byte
    rxbyte_tready = 1'b0;
    send_good(8'h11);
    send_good(8'h22);
    tick(10);
    check("t4 held tvalid", rxbyte_tvalid, 1'b1);
    check("t4 held tdata", rxbyte_tdata, 8'h11);
    check_stream("t4 stalled");
    rxbyte_tready = 1'b1;
    model_release();
    tick(5);
    check("t4 drained tvalid", rxbyte_tvalid, 1'b0);
    check_stream("t4 release");
    send_good(8'h33);
    tick(20);
    check_stream("t4 after");

    // 5: back-to-back frames with no idle gap
    send_good(8'h00);
    send_good(8'hFF);
    tick(20);
    check_stream("t5");

    // 6: reset during bit 3 while a beat is pending
    rxbyte_tready = 1'b0;
    b = 8'($urandom_range(0, 255));
    send_good(b);
    tick(5);
    check("t6 pending", rxbyte_tvalid, 1'b1);
    fr = {1'b1, 8'h96, 1'b0};
    for (int i = 0; i < 4 * TICS + 5; i++) begin
      uart_rxd = fr[i / TICS];
      tick(1);
    end
    aresetn = 1'b0;
    #1;
    check("t6 reset tvalid", rxbyte_tvalid, 1'b0);
    check("t6 reset tdata", rxbyte_tdata, 8'h00);
    model_held = 1'b0;
    uart_rxd = 1'b1;
    tick(3);
    aresetn = 1'b1;
    rxbyte_tready = 1'b1;
    tick(20);
    check_stream("t6 lost");
    send_good(8'h5A);
    tick(20);
    check_stream("t6 after");

    // random frames, random idle gaps, glitches away from the sample window
    for (int k = 0; k < 10; k++) begin
      b  = 8'($urandom_range(0, 255));
      gl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) * TICS + 1 : -1;
      tick($urandom_range(0, 15));
      send_frame(b, 1'b1, gl);
      model_frame(b, 1'b1);
    end
    tick(20);
    check_stream("random");

`ifdef AXIS_UART_RX_MAJORITY_EN
    // 7: single-cycle inverted pulse exactly at the bit-4 sample point
    send_frame(8'h0F, 1'b1, 5 * TICS + TICS / 2);
    model_frame(8'h0F, 1'b1);
    tick(20);
    check_stream("t7 majority");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
